// File: rtl/regfile_hilo_mp_if.sv
// regfile_hilo_mp_if: ID/WB-side bus of regfile_hilo_mp (GPR read ports, GPR write, HI/LO writes, mul/div occupancy); master drives requests, slave is the regfile
interface regfile_hilo_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int CNT_W  = 6,
  parameter int ADDR_W = $clog2(NREG)
);
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  hi_we;
  logic [DATA_W-1:0]     hi_wdata;
  logic                  lo_we;
  logic [DATA_W-1:0]     lo_wdata;
  logic [DATA_W-1:0]     hi_rdata;
  logic [DATA_W-1:0]     lo_rdata;
  logic                  md_start;
  logic [CNT_W-1:0]      md_cycles;
  logic                  hilo_rd;
  logic                  hilo_busy;
  logic                  stall_req;
  modport master (
    output raddr, we, waddr, wdata, hi_we, hi_wdata, lo_we, lo_wdata, md_start, md_cycles, hilo_rd,
    input  rdata, hi_rdata, lo_rdata, hilo_busy, stall_req
  );
  modport slave (
    input  raddr, we, waddr, wdata, hi_we, hi_wdata, lo_we, lo_wdata, md_start, md_cycles, hilo_rd,
    output rdata, hi_rdata, lo_rdata, hilo_busy, stall_req
  );
endinterface

// File: rtl/regfile_hilo_mp.sv
// regfile_hilo_mp: NRD-read GPR file + HI/LO with mul/div stall counter; ports clk, rst (sync, active-high), bus (regfile_hilo_mp_if.slave); define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_hilo_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int CNT_W  = 6
) (
  input logic clk,
  input logic rst,
  regfile_hilo_mp_if.slave bus
);
  localparam int ADDR_W = $clog2(NREG);
  logic [DATA_W-1:0]     regs [NREG];
  logic [DATA_W-1:0]     hi, lo;
  logic [CNT_W-1:0]      cnt;
  logic [NRD*DATA_W-1:0] rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else begin
      if (bus.we && bus.waddr != '0) regs[bus.waddr] <= bus.wdata;
      if (bus.hi_we) hi <= bus.hi_wdata;
      if (bus.lo_we) lo <= bus.lo_wdata;
      cnt <= (cnt != '0) ? cnt - CNT_W'(1) : bus.md_start ? bus.md_cycles : '0;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.raddr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rd[i*DATA_W +: DATA_W] = (a == '0) ? '0 : (bus.we && bus.waddr == a) ? bus.wdata : regs[a];
`else
    assign rd[i*DATA_W +: DATA_W] = (a == '0) ? '0 : regs[a];
`endif
  end
  assign bus.rdata = rd;
`ifdef REGFILE_BYPASS_EN
  assign bus.hi_rdata = bus.hi_we ? bus.hi_wdata : hi;
  assign bus.lo_rdata = bus.lo_we ? bus.lo_wdata : lo;
`else
  assign bus.hi_rdata = hi;
  assign bus.lo_rdata = lo;
`endif
  assign bus.hilo_busy = cnt != '0;
  assign bus.stall_req = bus.hilo_rd && cnt != '0;
endmodule

// File: tb/tb_regfile_hilo_mp.sv
// tb_regfile_hilo_mp: directed and randomized checks of regfile_hilo_mp against a cycle-indexed reference model
module tb_regfile_hilo_mp;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;
  int cyc = 0;
  int busy_end = 0;
  regfile_hilo_mp_if bus ();
  regfile_hilo_mp dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (a != 5'd0 && bus.we && bus.waddr == a) return bus.wdata;
`endif
    return (a == 5'd0) ? 32'h0 : m_regs[a];
  endfunction
  function automatic logic [31:0] exp_hi();
`ifdef REGFILE_BYPASS_EN
    if (bus.hi_we) return bus.hi_wdata;
`endif
    return m_hi;
  endfunction
  function automatic logic [31:0] exp_lo();
`ifdef REGFILE_BYPASS_EN
    if (bus.lo_we) return bus.lo_wdata;
`endif
    return m_lo;
  endfunction
  function automatic logic exp_busy();
    return cyc < busy_end;
  endfunction
  task automatic idle();
    rst = 1'b0;
    bus.raddr = '0;
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.hi_we = 1'b0;
    bus.hi_wdata = '0;
    bus.lo_we = 1'b0;
    bus.lo_wdata = '0;
    bus.md_start = 1'b0;
    bus.md_cycles = '0;
    bus.hilo_rd = 1'b0;
  endtask
  task automatic tick();
    if (rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      busy_end = 0;
    end else begin
      if (bus.we && bus.waddr != 5'd0) m_regs[bus.waddr] = bus.wdata;
      if (bus.hi_we) m_hi = bus.hi_wdata;
      if (bus.lo_we) m_lo = bus.lo_wdata;
      if (bus.md_start && bus.md_cycles != 6'd0 && !exp_busy()) busy_end = cyc + 1 + int'(bus.md_cycles);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.we = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 32'hDEADBEEF;
    bus.hi_we = 1'b1;
    bus.hi_wdata = 32'h5;
    bus.lo_we = 1'b1;
    bus.lo_wdata = 32'h6;
    bus.md_start = 1'b1;
    bus.md_cycles = 6'd4;
    tick();
    tick();
    idle();
    bus.hilo_rd = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(a), 5'(31 - a)};
      #1;
      checks++;
      if (bus.rdata !== 64'h0) begin
        errors++;
        $display("FAIL reset_rdata addr=%0d got %h exp 0", a, bus.rdata);
      end
    end
    checks++;
    if (bus.hi_rdata !== 32'h0 || bus.lo_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo got hi=%h lo=%h exp 0/0", bus.hi_rdata, bus.lo_rdata);
    end
    checks++;
    if (bus.hilo_busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got busy=%b stall=%b exp 0/0", bus.hilo_busy, bus.stall_req);
    end
    idle();
  endtask
  task automatic test_zero_reg();
    idle();
    bus.we = 1'b1;
    bus.waddr = 5'd0;
    bus.wdata = 32'hFFFFFFFF;
    tick();
    idle();
    #1;
    checks++;
    if (bus.rdata[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reg0_read got %h exp 0", bus.rdata[31:0]);
    end
    bus.we = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'h1234;
    tick();
    idle();
    bus.raddr = {5'd5, 5'd5};
    #1;
    checks++;
    if (bus.rdata !== {32'h1234, 32'h1234}) begin
      errors++;
      $display("FAIL dual_read_r5 got %h exp %h", bus.rdata, {32'h1234, 32'h1234});
    end
  endtask
  task automatic test_bypass();
    idle();
    bus.we = 1'b1;
    bus.waddr = 5'd7;
    bus.wdata = 32'hA5A5A5A5;
    bus.raddr = {5'd7, 5'd5};
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (bus.rdata[63:32] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h exp a5a5a5a5", bus.rdata[63:32]);
    end
`else
    if (bus.rdata[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle got %h exp 0", bus.rdata[63:32]);
    end
`endif
    tick();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.rdata[63:32] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL write_next_cycle got %h exp a5a5a5a5", bus.rdata[63:32]);
    end
    idle();
  endtask
  task automatic test_muldiv();
    int nb;
    idle();
    bus.hilo_rd = 1'b1;
    bus.md_start = 1'b1;
    bus.md_cycles = 6'd4;
    #1;
    checks++;
    if (bus.hilo_busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL md_issue_cycle got busy=%b stall=%b exp 0/0", bus.hilo_busy, bus.stall_req);
    end
    tick();
    bus.md_start = 1'b0;
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.hi_we = 1'b1;
        bus.hi_wdata = 32'h11;
        bus.lo_we = 1'b1;
        bus.lo_wdata = 32'h22;
      end
      #1;
      checks++;
      if (bus.hilo_busy !== 1'b1 || bus.stall_req !== 1'b1) begin
        errors++;
        $display("FAIL md_busy_cycle%0d got busy=%b stall=%b exp 1/1", k, bus.hilo_busy, bus.stall_req);
      end
      tick();
    end
    idle();
    bus.hilo_rd = 1'b1;
    #1;
    checks++;
    if (bus.hilo_busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL md_done got busy=%b stall=%b exp 0/0", bus.hilo_busy, bus.stall_req);
    end
    checks++;
    if (bus.hi_rdata !== 32'h11 || bus.lo_rdata !== 32'h22) begin
      errors++;
      $display("FAIL md_result got hi=%h lo=%h exp 11/22", bus.hi_rdata, bus.lo_rdata);
    end
    idle();
  endtask
  task automatic test_md_edges();
    int nb;
    idle();
    bus.md_start = 1'b1;
    bus.md_cycles = 6'd0;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.hilo_busy !== 1'b0) begin
        errors++;
        $display("FAIL md_zero_cycles cycle%0d got busy=%b exp 0", k, bus.hilo_busy);
      end
      tick();
    end
    bus.md_start = 1'b1;
    bus.md_cycles = 6'd4;
    tick();
    bus.md_start = 1'b0;
    nb = 0;
    for (int k = 0; k < 20 && (bus.hilo_busy === 1'b1 || k == 0); k++) begin
      if (bus.hilo_busy === 1'b1) nb++;
      bus.md_start = (nb == 2);
      bus.md_cycles = 6'd9;
      tick();
    end
    checks++;
    if (nb != 4 || bus.hilo_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_no_reload got busy_cycles=%0d busy_now=%b exp 4/0", nb, bus.hilo_busy);
    end
    idle();
  endtask
  task automatic test_rst_mid();
    idle();
    bus.hi_we = 1'b1;
    bus.hi_wdata = 32'hCAFE;
    bus.lo_we = 1'b1;
    bus.lo_wdata = 32'hBEEF;
    bus.md_start = 1'b1;
    bus.md_cycles = 6'd4;
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.hilo_busy !== 1'b0 || bus.hi_rdata !== 32'h0 || bus.lo_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_op got busy=%b hi=%h lo=%h exp 0/0/0", bus.hilo_busy, bus.hi_rdata, bus.lo_rdata);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.we = $urandom_range(0, 1) == 1;
      bus.waddr = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      bus.wdata = $urandom;
      bus.raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      bus.hi_we = $urandom_range(0, 3) == 0;
      bus.hi_wdata = $urandom;
      bus.lo_we = $urandom_range(0, 3) == 0;
      bus.lo_wdata = $urandom;
      bus.md_start = $urandom_range(0, 4) == 0;
      bus.md_cycles = 6'($urandom_range(0, 12));
      bus.hilo_rd = $urandom_range(0, 1) == 1;
      #1;
      checks++;
      if (bus.rdata[31:0] !== exp_rd(bus.raddr[4:0]) || bus.rdata[63:32] !== exp_rd(bus.raddr[9:5])) begin
        errors++;
        $display("FAIL rand_rdata n=%0d got %h exp %h", n, bus.rdata, {exp_rd(bus.raddr[9:5]), exp_rd(bus.raddr[4:0])});
      end
      checks++;
      if (bus.hi_rdata !== exp_hi() || bus.lo_rdata !== exp_lo()) begin
        errors++;
        $display("FAIL rand_hilo n=%0d got hi=%h lo=%h exp hi=%h lo=%h", n, bus.hi_rdata, bus.lo_rdata, exp_hi(), exp_lo());
      end
      checks++;
      if (bus.hilo_busy !== exp_busy() || bus.stall_req !== (exp_busy() && bus.hilo_rd)) begin
        errors++;
        $display("FAIL rand_busy n=%0d got busy=%b stall=%b exp busy=%b stall=%b", n, bus.hilo_busy, bus.stall_req, exp_busy(), exp_busy() && bus.hilo_rd);
      end
      tick();
    end
    idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_muldiv();
    test_md_edges();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
